// File: rtl/imuldiv_mul_div_req_queue_pkg.sv
// Shared definitions for the multiply/divide request queue.
//
// Contents:
//    FUNC_W / OPND_W / MSG_W : request message field widths
//    func_e                  : operation encodings carried in the func field
//    req_msg_t               : packed request layout {func, a, b}
//    is_legal_func()         : true for the operations the mul/div units implement
package imuldiv_mul_div_req_queue_pkg;

   localparam int unsigned FUNC_W = 3;
   localparam int unsigned OPND_W = 32;
   localparam int unsigned MSG_W  = FUNC_W + 2 * OPND_W;

   typedef enum logic [FUNC_W-1:0] {
      FUNC_MUL  = 3'd0,
      FUNC_DIV  = 3'd1,
      FUNC_DIVU = 3'd2,
      FUNC_REM  = 3'd3,
      FUNC_REMU = 3'd4
   } func_e;

   typedef struct packed {
      logic [FUNC_W-1:0] func;
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
   } req_msg_t;

   // Encodings are contiguous from FUNC_MUL, so everything above FUNC_REMU
   // is an operation no downstream unit understands.
   function automatic logic is_legal_func(input logic [FUNC_W-1:0] func);
      return (func <= FUNC_REMU);
   endfunction

endpackage

// File: rtl/imuldiv_mul_div_req_queue_msg_from_bits.sv
// Unpacks a flat request message into its func / a / b fields.
//
// Ports:
//    bits  in   MSG_W   packed request {func, a, b}
//    func  out  FUNC_W  operation code
//    a     out  OPND_W  first operand
//    b     out  OPND_W  second operand
module imuldiv_mul_div_req_queue_msg_from_bits
   import imuldiv_mul_div_req_queue_pkg::*;
(
   input  logic [MSG_W-1:0]  bits,
   output logic [FUNC_W-1:0] func,
   output logic [OPND_W-1:0] a,
   output logic [OPND_W-1:0] b
);

   req_msg_t msg;

   assign msg  = req_msg_t'(bits);
   assign func = msg.func;
   assign a    = msg.a;
   assign b    = msg.b;

endmodule

// File: rtl/imuldiv_mul_div_req_queue.sv
// Request queue in front of the iterative multiplier/divider.
//
// Buffers up to DEPTH requests in strict FIFO order. Requests whose func code
// is not a supported operation complete their handshake but are dropped, and
// illegal_func pulses for one cycle afterwards. Ready/valid are derived only
// from registered state, so there is no combinational path from deq_rdy to
// enq_rdy and no enq-to-deq bypass.
//
// Ports:
//    clk           in   1         clock, rising edge
//    reset         in   1         asynchronous reset, active low
//    enq_msg       in   MSG_W     request {func[66:64], a[63:32], b[31:0]}
//    enq_val       in   1         upstream request valid
//    enq_rdy       out  1         queue can accept a request
//    deq_msg_func  out  FUNC_W    func of head entry
//    deq_msg_a     out  OPND_W    operand a of head entry
//    deq_msg_b     out  OPND_W    operand b of head entry
//    deq_val       out  1         head entry valid
//    deq_rdy       in   1         downstream unit accepts head
//    num_free      out  clog2+1   number of empty entries
//    illegal_func  out  1         pulse: an illegal request was dropped
module imuldiv_mul_div_req_queue
   import imuldiv_mul_div_req_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [MSG_W-1:0]         enq_msg,
   input  logic                     enq_val,
   output logic                     enq_rdy,
   output logic [FUNC_W-1:0]        deq_msg_func,
   output logic [OPND_W-1:0]        deq_msg_a,
   output logic [OPND_W-1:0]        deq_msg_b,
   output logic                     deq_val,
   input  logic                     deq_rdy,
   output logic [$clog2(DEPTH):0]   num_free,
   output logic                     illegal_func
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [MSG_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  head_ptr;
   logic [PTR_W-1:0]  tail_ptr;
   logic [CNT_W-1:0]  count;
   logic              ready_q;
   logic [FUNC_W-1:0] enq_func;
   logic              enq_fire;
   logic              deq_fire;
   logic              enq_legal;
   logic              store;

   assign enq_func  = enq_msg[MSG_W-1 -: FUNC_W];
   assign enq_legal = is_legal_func(enq_func);

   // ready_q keeps enq_rdy low throughout reset and lets it rise on the
   // first clock edge after reset is released.
   assign enq_rdy  = ready_q && (count < DEPTH_CNT);
   assign deq_val  = (count != '0);
   assign enq_fire = enq_val && enq_rdy;
   assign deq_fire = deq_val && deq_rdy;
   assign store    = enq_fire && enq_legal;
   assign num_free = DEPTH_CNT - count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_q      <= 1'b0;
         head_ptr     <= '0;
         tail_ptr     <= '0;
         count        <= '0;
         illegal_func <= 1'b0;
      end else begin
         ready_q      <= 1'b1;
         illegal_func <= enq_fire && !enq_legal;
         if (store) begin
            tail_ptr <= tail_ptr + PTR_W'(1);
         end
         if (deq_fire) begin
            head_ptr <= head_ptr + PTR_W'(1);
         end
         // Simultaneous store and dequeue leave the occupancy unchanged.
         case ({store, deq_fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only entries between head and tail are meaningful.
   always_ff @(posedge clk) begin
      if (store) begin
         mem[tail_ptr] <= enq_msg;
      end
   end

   imuldiv_mul_div_req_queue_msg_from_bits u_head_unpack (
      .bits (mem[head_ptr]),
      .func (deq_msg_func),
      .a    (deq_msg_a),
      .b    (deq_msg_b)
   );

endmodule

// File: doc/imuldiv_mul_div_req_queue.md
IMULDIV_MUL_DIV_REQ_QUEUE -- requirements
Module: imuldiv_MulDivReqQueue

Interface
REQ-001 Parameter: DEPTH, default 4, number of request entries (power of two, 2..16).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 enq_msg  input  67  packed request: [66:64] func, [63:32] a, [31:0] b.
REQ-005 enq_val  input  1  upstream request valid.
REQ-006 enq_rdy  output  1  queue can accept a request.
REQ-007 deq_msg_func  output  3  func field of head entry.
REQ-008 deq_msg_a  output  32  operand a of head entry.
REQ-009 deq_msg_b  output  32  operand b of head entry.
REQ-010 deq_val  output  1  head entry valid; drives multiplier/divider req_val.
REQ-011 deq_rdy  input  1  downstream unit (mulreq_rdy) accepts head.
REQ-012 num_free  output  clog2(DEPTH)+1  count of empty entries.
REQ-013 illegal_func  output  1  one-cycle pulse: an illegal request was dropped.

Function
REQ-014 Enqueue fires when enq_val && enq_rdy; dequeue fires when deq_val && deq_rdy.
REQ-015 enq_rdy = (occupancy < DEPTH); derived from registered state only, never from deq_rdy.
REQ-016 deq_val = (occupancy > 0); deq_msg_* reflect head entry; no combinational enq-to-deq bypass.
REQ-017 Latency: request enqueued in cycle N into empty queue has deq_val=1 from cycle N+1.
REQ-018 Legal func codes: 0 mul, 1 div, 2 divu, 3 rem, 4 remu; codes 5-7 illegal.
REQ-019 Illegal-func enqueue fire: handshake completes, entry not stored, illegal_func=1 in following cycle only.
REQ-020 Strict FIFO order; head/tail pointers clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-021 Simultaneous enq and deq fire (legal func, not full): occupancy unchanged, both pointers advance.
REQ-022 Full queue: enq_rdy=0 even if deq_rdy=1 same cycle; enq accepted next cycle after space frees.
REQ-023 Empty queue: deq_rdy ignored; no pointer movement, no underflow.
REQ-024 num_free = DEPTH - occupancy, updated the cycle after each fire.
REQ-025 deq_msg_* hold stable while deq_val=1 and deq_rdy=0.
REQ-026 Unused storage contents undefined; deq_msg_* don't-care when deq_val=0.

Reset
REQ-027 While reset=0: occupancy 0, pointers 0, deq_val=0, enq_rdy=0, illegal_func=0, num_free=DEPTH.
REQ-028 enq_rdy=1 from first rising edge after reset deasserts.
REQ-029 Reset asserted mid-operation discards all entries immediately (asynchronous); no pending illegal_func pulse survives.
REQ-030 Storage array itself not reset.

Structure
REQ-031 Field widths (func 3, operand 32, message 67) and func encodings live in the shared imuldiv-MulDivReqMsg.v header.
REQ-032 Unpacking uses existing sub-module imuldiv_MulDivReqMsgFromBits on the head entry; no other sub-modules.
REQ-033 Illegal-func check uses named header constants, not literals.

Verification
REQ-034 Single: enq {0,00000008,00000003}, deq_rdy=1 -> deq_val cycle+1, func=0 a=00000008 b=00000003, num_free back to 4.
REQ-035 Fill: 4 enqs with deq_rdy=0 -> enq_rdy=0, num_free=0; 5th held; release deq_rdy -> order preserved, 5th accepted one cycle later.
REQ-036 Streaming: enq_val and deq_rdy high 10 cycles, ten distinct requests -> occupancy steady at 1, pointers wrap, all ten out in order.
REQ-037 Illegal: enq func=7 between two mul requests -> illegal_func one-cycle pulse, only two entries dequeued.
REQ-038 Reset mid-stream: 3 entries queued, reset=0 for one cycle -> deq_val=0 immediately, num_free=4, prior entries never appear.
REQ-039 End-to-end: queue feeding imuldiv_IntMulIterative, ffffffff*ffffffff and fffffff8*00000008 -> results 00000000_00000001, ffffffff_ffffffc0 in order.
